// File: rtl/mc_control_unit_if.sv
// Fetch and register-file/ALU datapath bundle for the multicycle sequencer.
// master = sequencer side, slave = memory/datapath side.
`timescale 1ns/1ps
interface mc_control_unit_if #(
   parameter int PC_WIDTH = 32
);
   logic                instr_req;
   logic [PC_WIDTH-1:0] instr_addr;
   logic                instr_valid;
   logic [31:0]         instr;
   logic [4:0]          Read1;
   logic [4:0]          Read2;
   logic [4:0]          WriteReg;
   logic [1:0]          RegWrite;
   logic [31:0]         WriteData;
   logic [3:0]          FuncCode;
   logic [1:0]          ALUOp;
   logic [31:0]         alu_result;
   logic                Zero;

   modport master (
      output instr_req, instr_addr,
      input  instr_valid, instr,
      output Read1, Read2, WriteReg,
      output RegWrite, WriteData,
      output FuncCode, ALUOp,
      input  alu_result, Zero
   );

   modport slave (
      input  instr_req, instr_addr,
      output instr_valid, instr,
      input  Read1, Read2, WriteReg,
      input  RegWrite, WriteData,
      input  FuncCode, ALUOp,
      output alu_result, Zero
   );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle control sequencer: fetch, decode, execute and write back
// MIPS-style words against an external register file and ALU.
`timescale 1ns/1ps
module mc_control_unit #(
   parameter int         PC_WIDTH    = 32,
   parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
   input  logic                clk,
   input  logic                rst,
   mc_control_unit_if.master   bus,
   output logic                halted,
   output logic                illegal,
   output logic [31:0]         instr_count
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_BRANCH,
      S_WIMM,
      S_HALT
   } state_e;

   state_e              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [31:0]         ir_q, ir_d;
   logic [31:0]         alu_q, alu_d;
   logic [31:0]         cnt_q, cnt_d;
   logic                illegal_q, illegal_d;

   logic [5:0]          op;
   logic [4:0]          rs;
   logic [4:0]          rt;
   logic [4:0]          rd;
   logic [15:0]         imm;
   logic [PC_WIDTH-1:0] imm_ext;
   logic [PC_WIDTH-1:0] pc_inc;

   assign op      = ir_q[31:26];
   assign rs      = ir_q[25:21];
   assign rt      = ir_q[20:16];
   assign rd      = ir_q[15:11];
   assign imm     = ir_q[15:0];
   assign imm_ext = PC_WIDTH'($signed(imm));
   assign pc_inc  = pc_q + PC_WIDTH'(1);

   assign bus.instr_addr = pc_q;
   assign bus.FuncCode   = ir_q[3:0];
   assign illegal        = illegal_q;
   assign instr_count    = cnt_q;

   // State register; reset abandons any in-flight fetch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers: pc, instruction, ALU capture, retire count, illegal pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q      <= '0;
         ir_q      <= '0;
         alu_q     <= '0;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         alu_q     <= alu_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
      end
   end

   // Next-state and next-register values.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      alu_d     = alu_q;
      cnt_d     = cnt_q;
      illegal_d = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            if (bus.instr_valid) begin
               ir_d    = bus.instr;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (op == 6'h00) begin
               state_d = S_EXEC;
            end else if (op == 6'h04) begin
               state_d = S_BRANCH;
            end else if (op == 6'h0F) begin
               state_d = S_WIMM;
            end else if (op == HALT_OPCODE) begin
               state_d = S_HALT;
            end else begin
               state_d   = S_FETCH;
               pc_d      = pc_inc;
               illegal_d = 1'b1;
            end
         end
         S_EXEC: begin
            alu_d   = bus.alu_result;
            state_d = S_WB;
         end
         S_WB, S_WIMM: begin
            pc_d    = pc_inc;
            cnt_d   = cnt_q + 32'd1;
            state_d = S_FETCH;
         end
         S_BRANCH: begin
            pc_d    = bus.Zero ? pc_inc + imm_ext : pc_inc;
            cnt_d   = cnt_q + 32'd1;
            state_d = S_FETCH;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // Moore outputs decoded from the registered state and instruction.
   always_comb begin
      bus.instr_req = 1'b0;
      bus.Read1     = '0;
      bus.Read2     = '0;
      bus.WriteReg  = '0;
      bus.RegWrite  = 2'b00;
      bus.WriteData = '0;
      bus.ALUOp     = 2'b00;
      halted        = 1'b0;
      if (state_q != S_FETCH) begin
         bus.Read1 = rs;
         bus.Read2 = rt;
      end
      unique case (state_q)
         S_FETCH: begin
            bus.instr_req = 1'b1;
         end
         S_EXEC: begin
            bus.ALUOp = 2'b10;
         end
         S_WB: begin
            bus.WriteReg  = rd;
            bus.WriteData = alu_q;
            bus.RegWrite  = (rd != 5'd0) ? 2'b01 : 2'b00;
         end
         S_BRANCH: begin
            bus.ALUOp = 2'b01;
         end
         S_WIMM: begin
            bus.WriteReg  = rt;
            bus.WriteData = {imm, 16'h0000};
            bus.RegWrite  = (rt != 5'd0) ? 2'b01 : 2'b00;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: R-type, BEQ, LUI, illegal,
// halt, fetch stall and asynchronous reset mid-instruction.
`timescale 1ns/1ps
module tb_mc_control_unit;

   localparam logic [31:0] R_ADD  = 32'h0022_1820;
   localparam logic [31:0] BEQ_M2 = 32'h1022_FFFE;
   localparam logic [31:0] LUI_7  = 32'h3C07_ABCD;
   localparam logic [31:0] LUI_0  = 32'h3C00_ABCD;
   localparam logic [31:0] ILL    = 32'h8C00_0000;
   localparam logic [31:0] HLT    = 32'hFC00_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        halted;
   logic        illegal;
   logic [31:0] instr_count;
   int          errs = 0;
   int          checks = 0;

   mc_control_unit_if #(.PC_WIDTH(32)) bus ();

   mc_control_unit #(
      .PC_WIDTH    (32),
      .HALT_OPCODE (6'h3F)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .halted      (halted),
      .illegal     (illegal),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a word in the FETCH cycle; returns one cycle later (DECODE).
   task automatic fetch(input logic [31:0] w);
      int n = 0;
      while (bus.instr_req !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      chk("fetch_req", {31'd0, bus.instr_req}, 32'd1);
      bus.instr       = w;
      bus.instr_valid = 1'b1;
      step();
      bus.instr_valid = 1'b0;
   endtask

   task automatic run_r();
      fetch(R_ADD);
      step();
      step();
      step();
   endtask

   initial begin
      int bad;
      rst             = 1'b1;
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      bus.alu_result  = '0;
      bus.Zero        = 1'b0;
      step();
      step();
      rst = 1'b0;

      chk("rst_req", {31'd0, bus.instr_req}, 32'd1);
      chk("rst_pc", bus.instr_addr, 32'd0);
      chk("rst_regwrite", {30'd0, bus.RegWrite}, 32'd0);
      chk("rst_aluop", {30'd0, bus.ALUOp}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_illegal", {31'd0, illegal}, 32'd0);
      chk("rst_count", instr_count, 32'd0);
      chk("rst_read1", {27'd0, bus.Read1}, 32'd0);
      chk("rst_wdata", bus.WriteData, 32'd0);

      // R-type add $3,$1,$2 at pc 0
      fetch(R_ADD);
      chk("r_dec_read1", {27'd0, bus.Read1}, 32'd1);
      chk("r_dec_read2", {27'd0, bus.Read2}, 32'd2);
      chk("r_dec_aluop", {30'd0, bus.ALUOp}, 32'd0);
      chk("r_func", {28'd0, bus.FuncCode}, 32'd0);
      bus.alu_result = 32'hCAFE_0001;
      step();
      chk("r_exec_aluop", {30'd0, bus.ALUOp}, 32'd2);
      chk("r_exec_regwrite", {30'd0, bus.RegWrite}, 32'd0);
      step();
      bus.alu_result = 32'h0;
      chk("r_wb_regwrite", {30'd0, bus.RegWrite}, 32'd1);
      chk("r_wb_waddr", {27'd0, bus.WriteReg}, 32'd3);
      chk("r_wb_wdata", bus.WriteData, 32'hCAFE_0001);
      chk("r_wb_aluop", {30'd0, bus.ALUOp}, 32'd0);
      step();
      chk("r_pc", bus.instr_addr, 32'd1);
      chk("r_count", instr_count, 32'd1);
      chk("r_fetch_regwrite", {30'd0, bus.RegWrite}, 32'd0);

      // Unknown opcode at pc 1
      fetch(ILL);
      chk("ill_dec_pulse", {31'd0, illegal}, 32'd0);
      step();
      chk("ill_pulse", {31'd0, illegal}, 32'd1);
      chk("ill_pc", bus.instr_addr, 32'd2);
      chk("ill_count", instr_count, 32'd1);
      chk("ill_req", {31'd0, bus.instr_req}, 32'd1);
      step();
      chk("ill_pulse_end", {31'd0, illegal}, 32'd0);

      // Fetch stall: valid low for 10 cycles
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.instr_req !== 1'b1 || bus.instr_addr !== 32'd2) bad++;
         step();
      end
      chk("stall_bad_cycles", bad, 32'd0);
      chk("stall_req", {31'd0, bus.instr_req}, 32'd1);

      // Advance pc 2 -> 5
      run_r();
      run_r();
      run_r();
      chk("adv_pc", bus.instr_addr, 32'd5);
      chk("adv_count", instr_count, 32'd4);

      // BEQ taken at pc 5
      bus.Zero = 1'b1;
      fetch(BEQ_M2);
      chk("beq_dec_aluop", {30'd0, bus.ALUOp}, 32'd0);
      step();
      chk("beq_aluop", {30'd0, bus.ALUOp}, 32'd1);
      chk("beq_regwrite", {30'd0, bus.RegWrite}, 32'd0);
      step();
      bus.Zero = 1'b0;
      chk("beq_t_pc", bus.instr_addr, 32'd4);
      chk("beq_t_count", instr_count, 32'd5);
      chk("beq_after_aluop", {30'd0, bus.ALUOp}, 32'd0);

      // BEQ not taken at pc 5
      run_r();
      chk("beq2_start_pc", bus.instr_addr, 32'd5);
      fetch(BEQ_M2);
      step();
      chk("beq_nt_regwrite", {30'd0, bus.RegWrite}, 32'd0);
      step();
      chk("beq_nt_pc", bus.instr_addr, 32'd6);
      chk("beq_nt_count", instr_count, 32'd7);

      // LUI $7, 0xABCD
      fetch(LUI_7);
      step();
      chk("lui_regwrite", {30'd0, bus.RegWrite}, 32'd1);
      chk("lui_waddr", {27'd0, bus.WriteReg}, 32'd7);
      chk("lui_wdata", bus.WriteData, 32'hABCD_0000);
      step();
      chk("lui_pc", bus.instr_addr, 32'd7);
      chk("lui_count", instr_count, 32'd8);

      // LUI $0 never writes
      fetch(LUI_0);
      step();
      chk("lui0_regwrite", {30'd0, bus.RegWrite}, 32'd0);
      step();
      chk("lui0_pc", bus.instr_addr, 32'd8);
      chk("lui0_count", instr_count, 32'd9);

      // Async reset during EXEC, stale valid held through reset
      fetch(R_ADD);
      step();
      chk("mid_exec_aluop", {30'd0, bus.ALUOp}, 32'd2);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_aluop", {30'd0, bus.ALUOp}, 32'd0);
      chk("arst_pc", bus.instr_addr, 32'd0);
      chk("arst_count", instr_count, 32'd0);
      chk("arst_req", {31'd0, bus.instr_req}, 32'd1);
      chk("arst_read1", {27'd0, bus.Read1}, 32'd0);
      bus.instr       = HLT;
      bus.instr_valid = 1'b1;
      step();
      rst             = 1'b0;
      bus.instr_valid = 1'b0;
      step();
      chk("stale_req", {31'd0, bus.instr_req}, 32'd1);
      chk("stale_halted", {31'd0, halted}, 32'd0);
      chk("stale_read1", {27'd0, bus.Read1}, 32'd0);

      // HALT at pc 1
      run_r();
      fetch(HLT);
      step();
      chk("halt_flag", {31'd0, halted}, 32'd1);
      chk("halt_req", {31'd0, bus.instr_req}, 32'd0);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (halted !== 1'b1 || bus.instr_req !== 1'b0 ||
             bus.instr_addr !== 32'd1 || bus.RegWrite !== 2'b00) bad++;
      end
      chk("halt_bad_cycles", bad, 32'd0);
      chk("halt_count", instr_count, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("unhalt_flag", {31'd0, halted}, 32'd0);
      chk("unhalt_pc", bus.instr_addr, 32'd0);
      chk("unhalt_req", {31'd0, bus.instr_req}, 32'd1);
      run_r();
      chk("resume_pc", bus.instr_addr, 32'd1);
      chk("resume_count", instr_count, 32'd1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multicycle control sequencer that drives the register-file/ALU datapath.
- Fetches 32-bit MIPS-style instructions over a req/valid handshake and decodes them.
- Sequences the RF read ports, ALUOp/FuncCode, and the RF write port; consumes the ALU result and Zero flag.
- Maintains the PC and the branch logic.

Parameters:
- PC_WIDTH, 32, width of the word-addressed program counter.
- HALT_OPCODE, 6'h3F, opcode that stops the sequencer.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- instr_req  output  1  fetch request; high only in FETCH.
- instr_addr  output  PC_WIDTH  word address to fetch (= pc).
- instr_valid  input  1  instr holds the word for instr_addr.
- instr  input  32  fetched instruction.
- Read1  output  5  RF read port 1 (rs).
- Read2  output  5  RF read port 2 (rt).
- WriteReg  output  5  RF write address.
- RegWrite  output  2  2'b01 = write this cycle; 2'b00 = no write; 2'b1x never driven.
- WriteData  output  32  RF write data.
- FuncCode  output  4  instr[3:0] (funct low bits).
- ALUOp  output  2  00 add, 01 subtract, 10 R-type (use FuncCode).
- alu_result  input  32  datapath ALU output.
- Zero  input  1  ALU zero flag.
- halted  output  1  sequencer stopped.
- illegal  output  1  one-cycle pulse on an unknown opcode.
- instr_count  output  32  retired-instruction count.

Behaviour:
- Reset (async, immediate, any state):
  - state = FETCH, pc = 0, ir = 0, alu_q = 0, instr_count = 0.
  - halted = 0, illegal = 0, RegWrite = 00.
  - ALUOp = 00, Read1/Read2/WriteReg = 0, WriteData = 0.
  - An in-flight fetch is abandoned; a late instr_valid is ignored until the next FETCH.
- Instruction fields:
  - op = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], imm = [15:0].
- Read1/Read2 are driven from ir.rs/ir.rt in every state except FETCH (0 in FETCH).
- FuncCode = ir[3:0] at all times.
- States:
  - FETCH:
    - instr_req = 1, instr_addr = pc.
    - On instr_valid: ir <= instr, go to DECODE. Otherwise stay (unbounded wait).
  - DECODE: RF read settles. Next state by op:
    - 6'h00 → EXEC.
    - 6'h04 (BEQ) → BRANCH.
    - 6'h0F (LUI) → WIMM.
    - HALT_OPCODE → HALT.
    - Anything else → FETCH, with illegal = 1 for the cycle after DECODE, pc <= pc+1, and no instr_count increment.
  - EXEC: ALUOp = 10, alu_q <= alu_result → WB.
  - WB:
    - WriteReg = ir.rd, WriteData = alu_q.
    - RegWrite = 01 unless rd == 0 (then 00).
    - pc <= pc+1, instr_count++ → FETCH.
  - BRANCH:
    - ALUOp = 01.
    - If Zero: pc <= pc + 1 + sign_extend(imm) (mod 2^PC_WIDTH, wraps).
    - Else: pc <= pc+1.
    - instr_count++ → FETCH.
  - WIMM:
    - WriteReg = ir.rt, WriteData = {imm, 16'h0}.
    - RegWrite = 01 unless rt == 0.
    - pc <= pc+1, instr_count++ → FETCH.
  - HALT:
    - halted = 1, instr_req = 0, RegWrite = 00.
    - pc frozen (points at the HALT word). HALT does not count as retired.
    - Leave only via rst.
- Outside WB/WIMM: RegWrite = 00. Outside EXEC/BRANCH: ALUOp = 00. All control outputs are registered or decoded from the registered state only (Moore).
- Latency with instr_valid asserted in the FETCH cycle:
  - R-type: 4 cycles.
  - BEQ: 3 cycles.
  - LUI: 3 cycles.
  - Illegal: 2 cycles + the pulse overlaps the next FETCH.
- pc wraps from 2^PC_WIDTH−1 to 0 on increment.
- instr_count wraps at 2^32.

Test Plan:
- Reset, then a stream of R-type add $3,$1,$2 (instr 32'h00221820) with instr_valid in the same cycle:
  - instr_req in cycle 0.
  - RegWrite = 01, WriteReg = 3, WriteData = alu_result sampled in EXEC, in cycle 3.
  - pc = 1 and instr_count = 1 after cycle 3.
- BEQ imm = 16'hFFFE at pc = 5:
  - Zero = 1 → pc = 4.
  - Zero = 0 → pc = 6.
  - ALUOp = 01 only in the BRANCH cycle; RegWrite never 01.
- LUI rt = 7, imm = 16'hABCD → WriteData = 32'hABCD0000, WriteReg = 7, RegWrite = 01 in cycle 2.
- LUI rt = 0 → RegWrite stays 00.
- op = 6'h3F → halted = 1, instr_req = 0, pc unchanged for 20 cycles. Assert rst → pc = 0, halted = 0, FETCH resumes.
- op = 6'h23 (unknown) → illegal high exactly 1 cycle, pc + 1, instr_count unchanged.
- Hold instr_valid = 0 for 10 cycles: instr_req stays 1, no state change.
- Assert rst mid-EXEC: all outputs return to their reset values at once, and a stale instr_valid one cycle later is ignored.
